alu_mux_sequencer: RTL and testbench



---
 rtl/alu_mux_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_mux_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mux_sequencer.sv
// Command-queued sequencer for the 16-way ALU result mux: FIFO of selects, settle cycle, captured result on valid/ready.
// Optional macro ALU_SEQ_ZFLAG_EN adds the registered res_zero output.
module alu_mux_sequencer #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  input  logic [3:0]               cmd_sel,
  output logic                     cmd_ready,
  input  logic                     flush,
  output logic [3:0]               mux_sel,
  input  logic [W-1:0]             mux_z,
  output logic                     res_valid,
  output logic [W-1:0]             res_data,
  output logic [3:0]               res_sel,
  input  logic                     res_ready,
`ifdef ALU_SEQ_ZFLAG_EN
  output logic                     res_zero,
`endif
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic            w_pop, w_push, w_nonempty;
  logic [3:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic [3:0]      r_mux_sel, r_res_sel;
  logic [W-1:0]    r_res_data;
  logic            r_res_valid;

  // Ready looks only at the registered count, so a same-cycle pop never opens a slot.
  assign w_nonempty = (r_count != '0);
  assign cmd_ready  = (r_count < CW'(DEPTH)) && !flush;
  assign w_push     = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (res_ready) begin
          w_pop       = w_nonempty;
          w_state_nxt = w_nonempty ? S_SETTLE : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= cmd_sel;
  end

  // A pop under flush still reads the old head before the pointers clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_sel   <= '0;
      r_res_data  <= '0;
      r_res_sel   <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_pop) r_mux_sel <= r_mem[r_rptr];
      if (r_state == S_SETTLE) begin
        r_res_data  <= mux_z;
        r_res_sel   <= r_mux_sel;
        r_res_valid <= 1'b1;
      end else if (r_state == S_HOLD && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  logic r_res_zero;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_res_zero <= 1'b0;
    else if (r_state == S_SETTLE) r_res_zero <= (mux_z == '0);
  end
  assign res_zero = r_res_zero;
`endif

  assign mux_sel   = r_mux_sel;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_sel   = r_res_sel;
  assign count     = r_count;
  assign busy      = (r_state != S_IDLE) || w_nonempty;

endmodule

// File: tb/tb_alu_mux_sequencer.sv
// Bench for alu_mux_sequencer: directed scenarios plus random traffic against a queue-based reference model.
module tb_alu_mux_sequencer;
  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, flush, res_ready;
  logic [3:0]    cmd_sel;
  logic          cmd_ready, res_valid, busy;
  logic [3:0]    mux_sel, res_sel;
  logic [W-1:0]  mux_z, res_data;
  logic [CW-1:0] count;
`ifdef ALU_SEQ_ZFLAG_EN
  logic          res_zero;
`endif

  logic [W-1:0]  lut [16];
  assign mux_z = lut[mux_sel];

  always #5 clk = ~clk;

  alu_mux_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_sel(cmd_sel),
    .cmd_ready(cmd_ready), .flush(flush), .mux_sel(mux_sel), .mux_z(mux_z),
    .res_valid(res_valid), .res_data(res_data), .res_sel(res_sel),
    .res_ready(res_ready),
`ifdef ALU_SEQ_ZFLAG_EN
    .res_zero(res_zero),
`endif
    .busy(busy), .count(count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 settling, 2 holding a result.
  logic [3:0]   q [$];
  int           ph;
  logic [3:0]   m_sel, m_rsel;
  logic [W-1:0] m_rdata;
  logic         m_rv, m_rz;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ph = 0; m_sel = '0; m_rsel = '0; m_rdata = '0; m_rv = 1'b0; m_rz = 1'b0;
  endtask

  task automatic model_step();
    bit acc, pop;
    acc = cmd_valid && (q.size() < DEPTH) && !flush;
    pop = (q.size() > 0) && ((ph == 0) || (ph == 2 && res_ready));
    if (ph == 1) begin
      m_rdata = lut[m_sel]; m_rsel = m_sel; m_rz = (lut[m_sel] == '0); m_rv = 1'b1; ph = 2;
    end else if (ph == 2) begin
      if (res_ready) begin m_rv = 1'b0; ph = pop ? 1 : 0; end
    end else begin
      ph = pop ? 1 : 0;
    end
    if (pop) m_sel = q.pop_front();
    if (flush) q.delete();
    if (acc) q.push_back(cmd_sel);
  endtask

  task automatic chk_all();
    chk("mux_sel", W'(mux_sel), W'(m_sel));
    chk("res_valid", W'(res_valid), W'(m_rv));
    chk("res_data", res_data, m_rdata);
    chk("res_sel", W'(res_sel), W'(m_rsel));
    chk("count", W'(count), W'(q.size()));
    chk("busy", W'(busy), W'((ph != 0) || (q.size() != 0)));
`ifdef ALU_SEQ_ZFLAG_EN
    chk("res_zero", W'(res_zero), W'(m_rz));
`endif
  endtask

  // One clock: drive inputs, check combinational ready, clock, check registered outputs.
  task automatic cyc(input logic v, input logic [3:0] s, input logic fl, input logic rr);
    cmd_valid = v; cmd_sel = s; flush = fl; res_ready = rr;
    #1;
    chk("cmd_ready", W'(cmd_ready), W'((q.size() < DEPTH) && !fl));
    @(posedge clk);
    model_step();
    #1;
    chk_all();
  endtask

  initial begin
    for (int k = 0; k < 16; k++) lut[k] = $urandom;
    lut[0] = '0;
    lut[5] = 32'hA5A5_0005;
    cmd_valid = 0; cmd_sel = 0; flush = 0; res_ready = 0;
    rst_n = 0;
    model_reset();
    #3;
    chk_all();
    chk("reset_cmd_ready", W'(cmd_ready), W'(1));
    @(negedge clk);
    rst_n = 1;

    // Single op: accepted at E0, mux_sel at E1, result at E2.
    cyc(1, 4'h5, 0, 0);
    cyc(0, 0, 0, 0);
    chk("lat_mux_sel", W'(mux_sel), W'(5));
    cyc(0, 0, 0, 0);
    chk("lat_res_data", res_data, 32'hA5A5_0005);
    chk("lat_res_valid", W'(res_valid), W'(1));
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Back-to-back with res_ready held.
    cyc(1, 4'h1, 0, 1);
    cyc(1, 4'h2, 0, 1);
    cyc(1, 4'h3, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    chk("b2b_idle", W'(busy), W'(0));

    // Backpressure: five cycles stalled in HOLD.
    cyc(1, 4'h7, 0, 0);
    cyc(1, 4'h9, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("bp_sel_held", W'(res_sel), W'(7));
    chk("bp_mux_held", W'(mux_sel), W'(7));
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // Full FIFO: DEPTH+2 pushes under backpressure, then drain.
    for (int i = 0; i < DEPTH + 2; i++) cyc(1, 4'(i + 3), 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 4'hF, 0, 0);
    chk("full_count", W'(count), W'(DEPTH));
    chk("full_ready", W'(cmd_ready), W'(0));
    for (int i = 0; i < 2 * DEPTH + 6; i++) cyc(0, 0, 0, 1);

    // Flush during HOLD with queued commands, simultaneous push dropped.
    for (int i = 0; i < 5; i++) cyc(1, 4'(i + 8), 0, 0);
    cyc(1, 4'h2, 1, 0);
    chk("flush_count", W'(count), W'(0));
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 2 * DEPTH + 6; i++) cyc(0, 0, 0, 1);

    // Zero-valued mux output.
    cyc(1, 4'h0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Reset asserted mid-operation while in SETTLE with commands queued.
    cyc(1, 4'h4, 0, 0);
    cyc(1, 4'h6, 0, 0);
    cyc(1, 4'hA, 0, 0);
    cyc(1, 4'hB, 0, 1);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk_all();
    chk("rst_cmd_ready", W'(cmd_ready), W'(1));
    cmd_valid = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    cyc(1, 4'hC, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
